output_port_vc_arbiter: RTL



---
 rtl/exanet_arb_pkg.sv | 15 +
 rtl/rr_input_selector.sv | 32 +++
 rtl/output_port_vc_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/exanet_arb_pkg.sv
// Shared types and index helpers for the Exanet output-port arbiter.
package exanet_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2
    } arb_state_t;

    // Bit position of (prio, vc) inside a per-input request vector.
    function automatic int vc_index(input int prio, input int vc, input int vc_num);
        return prio * vc_num + vc;
    endfunction

endpackage

// File: rtl/rr_input_selector.sv
// Round-robin input picker: first set bit of mask at or after rr_ptr, wrapping.
module rr_input_selector #(
    parameter int unsigned input_num = 4
) (
    input  logic [input_num-1:0]                                   mask,
    input  logic [((input_num > 1) ? $clog2(input_num) : 1)-1:0]   rr_ptr,
    output logic [((input_num > 1) ? $clog2(input_num) : 1)-1:0]   winner,
    output logic                                                   valid
);

    localparam int unsigned IW = (input_num > 1) ? $clog2(input_num) : 1;
    localparam int unsigned SW = IW + 1;

    logic [input_num-1:0] rot;
    logic [IW-1:0]        offset;
    logic [SW-1:0]        sum;

    // Rotate the doubled mask so rr_ptr lands at bit 0, then take the lowest set bit.
    always_comb begin
        rot    = input_num'({mask, mask} >> rr_ptr);
        offset = '0;
        for (int j = int'(input_num) - 1; j >= 0; j--) begin
            if (rot[j]) offset = IW'(j);
        end
        sum = {1'b0, rr_ptr} + {1'b0, offset};
        if (sum >= SW'(input_num)) sum = sum - SW'(input_num);
        winner = sum[IW-1:0];
    end

    assign valid = |mask;

endmodule

// File: rtl/output_port_vc_arbiter.sv
// Output-port VC arbiter: priority then round-robin input selection, one-cycle
// cts pulse, grant held until last. Define OUTPUT_ARB_CREDIT_CHECK_EN to gate
// eligibility with i_credit_avail.
module output_port_vc_arbiter
    import exanet_arb_pkg::*;
#(
    parameter int unsigned vc_num    = 3,
    parameter int unsigned prio_num  = 2,
    parameter int unsigned input_num = 4
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic [vc_num*prio_num-1:0]          i_request [input_num],
    input  logic [vc_num*prio_num-1:0]          i_credit_avail,
    input  logic                                last,
    output logic                                cts,
    output logic [$clog2(input_num)-1:0]        selected_input,
    output logic [$clog2(vc_num*prio_num)-1:0]  selected_vc,
    output logic                                busy
);

    localparam int unsigned VB = vc_num * prio_num;
    localparam int unsigned IW = $clog2(input_num);
    localparam int unsigned VW = $clog2(VB);
    localparam int unsigned PW = (prio_num > 1) ? $clog2(prio_num) : 1;

    arb_state_t             state, state_next;
    logic [IW-1:0]          rr_ptr, rr_ptr_next;
    logic [IW-1:0]          sel_input_next;
    logic [VW-1:0]          sel_vc_next;
    logic [VB-1:0]          elig [input_num];
    logic [prio_num-1:0]    level_any;
    logic [PW-1:0]          win_prio;
    logic [input_num-1:0]   input_mask;
    logic [IW-1:0]          win_input;
    logic                   win_valid;
    logic [VW-1:0]          win_vc;

`ifdef OUTPUT_ARB_CREDIT_CHECK_EN
    // Eligible = request with downstream credit.
    always_comb begin
        for (int i = 0; i < int'(input_num); i++) elig[i] = i_request[i] & i_credit_avail;
    end
`else
    logic credit_unused;
    assign credit_unused = ^i_credit_avail;

    // Eligible = request alone; credit port is not consulted.
    always_comb begin
        for (int i = 0; i < int'(input_num); i++) elig[i] = i_request[i];
    end
`endif

    // Per-priority-level reduction across all inputs.
    always_comb begin
        level_any = '0;
        for (int p = 0; p < int'(prio_num); p++)
            for (int i = 0; i < int'(input_num); i++)
                for (int v = 0; v < int'(vc_num); v++)
                    if (elig[i][vc_index(p, v, int'(vc_num))]) level_any[p] = 1'b1;
    end

    // Highest populated priority level wins.
    always_comb begin
        win_prio = '0;
        for (int p = 0; p < int'(prio_num); p++)
            if (level_any[p]) win_prio = PW'(p);
    end

    // Inputs with any eligible bit at the winning level.
    always_comb begin
        for (int i = 0; i < int'(input_num); i++) begin
            input_mask[i] = 1'b0;
            for (int p = 0; p < int'(prio_num); p++)
                for (int v = 0; v < int'(vc_num); v++)
                    if (PW'(p) == win_prio && elig[i][vc_index(p, v, int'(vc_num))])
                        input_mask[i] = 1'b1;
        end
    end

    rr_input_selector #(
        .input_num (input_num)
    ) u_rr_sel (
        .mask   (input_mask),
        .rr_ptr (rr_ptr),
        .winner (win_input),
        .valid  (win_valid)
    );

    // Lowest eligible VC of the winning input at the winning level.
    always_comb begin
        win_vc = '0;
        for (int p = 0; p < int'(prio_num); p++)
            for (int v = int'(vc_num) - 1; v >= 0; v--)
                if (PW'(p) == win_prio && elig[win_input][vc_index(p, v, int'(vc_num))])
                    win_vc = VW'(vc_index(p, v, int'(vc_num)));
    end

    // Next-state, winner capture, pointer update and cts.
    always_comb begin
        state_next     = state;
        sel_input_next = selected_input;
        sel_vc_next    = selected_vc;
        rr_ptr_next    = rr_ptr;
        cts            = 1'b0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    sel_input_next = win_input;
                    sel_vc_next    = win_vc;
                    state_next     = GRANT;
                end
            end
            GRANT: begin
                cts = i_request[selected_input][selected_vc];
                if (cts) begin
                    rr_ptr_next = (selected_input == IW'(input_num - 1)) ? '0
                                                                         : selected_input + IW'(1);
                    state_next  = XFER;
                end else begin
                    state_next  = IDLE;
                end
            end
            XFER: begin
                if (last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= IDLE;
            selected_input <= '0;
            selected_vc    <= '0;
            rr_ptr         <= '0;
            busy           <= 1'b0;
        end else begin
            state          <= state_next;
            selected_input <= sel_input_next;
            selected_vc    <= sel_vc_next;
            rr_ptr         <= rr_ptr_next;
            busy           <= (state_next != IDLE);
        end
    end

endmodule
